// File: rtl/pixel_word_fetch.sv
// Fetches a contiguous block of 32-bit words and presents each as four 8-bit pixel lanes.
// Optional stall counter output enabled by defining PIXEL_FETCH_STALL_CNT_EN.
module pixel_word_fetch #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_words,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic [7:0]            pixel1,
    output logic [7:0]            pixel2,
    output logic [7:0]            pixel3,
    output logic [7:0]            pixel4,
    output logic                  pixels_valid,
    input  logic                  pixels_ready,
    output logic                  busy,
    output logic                  done
`ifdef PIXEL_FETCH_STALL_CNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDone} state_e;

    localparam logic [3:0]            LatInit = 4'(MEM_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] num_q, num_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            lat_q, lat_d;
    logic [31:0]           word_q, word_d;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  start_acc;

    assign cur_addr = base_q + idx_q;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        num_d     = num_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        lat_d     = lat_q;
        word_d    = word_q;
        start_acc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (num_words != '0) begin
                        base_d  = base_addr;
                        num_d   = num_words;
                        idx_d   = '0;
                        state_d = StReq;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StReq: begin
                addr_d  = cur_addr;
                lat_d   = LatInit;
                state_d = StWait;
            end
            StWait: begin
                // Read data is valid during the last counted wait cycle.
                if (lat_q == 4'd0) begin
                    word_d  = mem_rdata;
                    state_d = StHold;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            StHold: begin
                if (pixels_ready) begin
                    if (idx_q == num_q - AddrOne) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + AddrOne;
                        state_d = StReq;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            lat_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            word_q  <= word_d;
        end
    end

    // Address is driven live in REQ and held from the register elsewhere.
    assign mem_rd_en    = (state_q == StReq);
    assign mem_addr     = (state_q == StReq) ? cur_addr : addr_q;
    assign pixels_valid = (state_q == StHold);
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign pixel1       = word_q[7:0];
    assign pixel2       = word_q[15:8];
    assign pixel3       = word_q[23:16];
    assign pixel4       = word_q[31:24];

`ifdef PIXEL_FETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (state_q == StHold && !pixels_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_pixel_word_fetch.sv
// Directed bench for pixel_word_fetch: one latency-1 instance for the main block tests and a
// latency-3 instance for the reset-during-wait test; reads and pixel words are scoreboarded.
module tb_pixel_word_fetch;

    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready = 1'b1;

    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_words = '0;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [31:0]   rdata;
    logic [7:0]    p1, p2, p3, p4;
    logic          valid, busy, done;
    logic [15:0]   stall;

    logic          start3 = 1'b0;
    logic [AW-1:0] base3 = '0;
    logic [AW-1:0] num3 = '0;
    logic          rd_en3;
    logic [AW-1:0] addr3;
    logic [31:0]   rdata3;
    logic [7:0]    q1, q2, q3, q4;
    logic          valid3, busy3, done3;
    logic [15:0]   stall3;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int rd3_cnt = 0;
    int done3_cnt = 0;

    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_word[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pixel_word_fetch #(.ADDR_WIDTH(AW), .MEM_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .mem_rd_en(rd_en), .mem_addr(addr), .mem_rdata(rdata),
        .pixel1(p1), .pixel2(p2), .pixel3(p3), .pixel4(p4),
        .pixels_valid(valid), .pixels_ready(ready), .busy(busy), .done(done)
`ifdef PIXEL_FETCH_STALL_CNT_EN
        , .stall_count(stall)
`endif
    );

    pixel_word_fetch #(.ADDR_WIDTH(AW), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .base_addr(base3), .num_words(num3),
        .mem_rd_en(rd_en3), .mem_addr(addr3), .mem_rdata(rdata3),
        .pixel1(q1), .pixel2(q2), .pixel3(q3), .pixel4(q4),
        .pixels_valid(valid3), .pixels_ready(ready), .busy(busy3), .done(done3)
`ifdef PIXEL_FETCH_STALL_CNT_EN
        , .stall_count(stall3)
`endif
    );

`ifndef PIXEL_FETCH_STALL_CNT_EN
    assign stall  = '0;
    assign stall3 = '0;
`endif

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        if (a == 16'h0010) return 32'hDDCCBBAA;
        return {a ^ 16'h5A3C, ~a};
    endfunction

    // Memory models: data is only meaningful in the cycle it is due, garbage otherwise.
    logic          m1_v;
    logic [AW-1:0] m1_a;
    logic [2:0]    m3_v;
    logic [AW-1:0] m3_a[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_v <= 1'b0;
            m1_a <= '0;
            m3_v <= '0;
            for (int i = 0; i < 3; i++) m3_a[i] <= '0;
        end else begin
            m1_v    <= rd_en;
            m1_a    <= addr;
            m3_v    <= {m3_v[1:0], rd_en3};
            m3_a[0] <= addr3;
            m3_a[1] <= m3_a[0];
            m3_a[2] <= m3_a[1];
        end
    end

    assign rdata  = m1_v ? mem_word(m1_a) : 32'hBAD0BAD0;
    assign rdata3 = m3_v[2] ? mem_word(m3_a[2]) : 32'hBAD0BAD0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (!rst) begin
            if (rd_en) begin
                rd_cnt++;
                n_cmp++;
                assert (exp_addr.size() > 0) else begin
                    n_err++;
                    $error("FAIL unexpected_read: observed addr %h expected no read", addr);
                end
                if (exp_addr.size() > 0) check("rd_addr", 32'(addr), 32'(exp_addr.pop_front()));
            end
            if (valid && ready) begin
                hs_cnt++;
                n_cmp++;
                assert (exp_word.size() > 0) else begin
                    n_err++;
                    $error("FAIL unexpected_handshake: observed %h expected none", {p4, p3, p2, p1});
                end
                if (exp_word.size() > 0) check("pixels", {p4, p3, p2, p1}, exp_word.pop_front());
            end
            if (done)   done_cnt++;
            if (rd_en3) rd3_cnt++;
            if (done3)  done3_cnt++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // which: 0 valid, 1 done, 2 valid3, 3 done3
    task automatic wait_sig(input int which, input int bound, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            case (which)
                0:       got = valid;
                1:       got = done;
                2:       got = valid3;
                default: got = done3;
            endcase
            if (got) break;
            step();
        end
        n_cmp++;
        assert (got) else begin
            n_err++;
            $error("FAIL %s: observed timeout after %0d cycles expected event", tag, bound);
        end
    endtask

    task automatic push(input logic [AW-1:0] a);
        exp_addr.push_back(a);
        exp_word.push_back(mem_word(a));
    endtask

    initial begin
        int r0, h0, d0, kc;
        int rc[$];
        bit seen;
        logic [31:0] w;

        #1;
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_pixels", {p4, p3, p2, p1}, 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single word, latency 1
        r0 = rd_cnt;
        push(16'h0010);
        base_addr = 16'h0010;
        num_words = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_rd_en_k1", 32'(rd_en), 32'd1);
        check("t1_addr_k1", 32'(addr), 32'h0010);
        check("t1_busy_k1", 32'(busy), 32'd1);
        step();
        check("t1_valid_k2", 32'(valid), 32'd0);
        check("t1_rd_en_k2", 32'(rd_en), 32'd0);
        step();
        check("t1_valid_k3", 32'(valid), 32'd1);
        check("t1_lanes_k3", {p4, p3, p2, p1}, 32'hDDCCBBAA);
        check("t1_done_k3", 32'(done), 32'd0);
        step();
        check("t1_done_k4", 32'(done), 32'd1);
        check("t1_valid_k4", 32'(valid), 32'd0);
        check("t1_lanes_hold", {p4, p3, p2, p1}, 32'hDDCCBBAA);
        step();
        check("t1_done_k5", 32'(done), 32'd0);
        check("t1_busy_k5", 32'(busy), 32'd0);
        check("t1_addr_hold", 32'(addr), 32'h0010);
        check("t1_reads", 32'(rd_cnt - r0), 32'd1);

        // Four words, ready high
        r0 = rd_cnt;
        h0 = hs_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i));
        base_addr = 16'h0100;
        num_words = 16'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (rd_en) rc.push_back(cyc);
            if (done) seen = 1'b1;
            else step();
        end
        check("t2_done_seen", 32'(seen), 32'd1);
        check("t2_read_cnt", 32'(rc.size()), 32'd4);
        for (int i = 1; i < rc.size(); i++) check("t2_spacing", 32'(rc[i] - rc[i-1]), 32'd3);
        step();
        check("t2_handshakes", 32'(hs_cnt - h0), 32'd4);
        check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t2_reads", 32'(rd_cnt - r0), 32'd4);
        check("t2_sb_empty", 32'(exp_addr.size() + exp_word.size()), 32'd0);

        // Backpressure on word 0
        ready = 1'b0;
        push(16'h0200);
        push(16'h0201);
        base_addr = 16'h0200;
        num_words = 16'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_sig(0, 10, "t3_valid_timeout");
        w = {p4, p3, p2, p1};
        check("t3_word0", w, mem_word(16'h0200));
        r0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_valid_stable", 32'(valid), 32'd1);
            check("t3_lanes_stable", {p4, p3, p2, p1}, w);
            check("t3_no_read", 32'(rd_en), 32'd0);
        end
`ifdef PIXEL_FETCH_STALL_CNT_EN
        check("t3_stall_count", 32'(stall), 32'd5);
`endif
        check("t3_reads_in_stall", 32'(rd_cnt - r0), 32'd0);
        ready = 1'b1;
        wait_sig(1, 20, "t3_done_timeout");
        step();
        check("t3_sb_empty", 32'(exp_addr.size() + exp_word.size()), 32'd0);

        // Address wrap
        r0 = rd_cnt;
        push(16'hFFFF);
        push(16'h0000);
        base_addr = 16'hFFFF;
        num_words = 16'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_sig(1, 20, "t4_done_timeout");
        step();
        check("t4_reads", 32'(rd_cnt - r0), 32'd2);
        check("t4_addr_hold", 32'(addr), 32'h0000);

        // Zero-length block
        r0 = rd_cnt;
        d0 = done_cnt;
        base_addr = 16'h1234;
        num_words = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_done", 32'(done), 32'd1);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_rd_en", 32'(rd_en), 32'd0);
        step();
        check("t5_done_after", 32'(done), 32'd0);
        check("t5_busy_after", 32'(busy), 32'd0);
        check("t5_reads", 32'(rd_cnt - r0), 32'd0);
        check("t5_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Reset during WAIT on the latency-3 instance, with a start pulse while busy
        base3 = 16'h0300;
        num3 = 16'd2;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        check("t6_rd_en3", 32'(rd_en3), 32'd1);
        check("t6_addr3", 32'(addr3), 32'h0300);
        step();
        base3 = 16'h0555;
        num3 = 16'd0;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        check("t6_busy_wait", 32'(busy3), 32'd1);
        check("t6_no_read_wait", 32'(rd_en3), 32'd0);
        check("t6_no_done_wait", 32'(done3), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_rd_en", 32'(rd_en3), 32'd0);
        check("t6_rst_addr", 32'(addr3), 32'd0);
        check("t6_rst_pixels", {q4, q3, q2, q1}, 32'd0);
        check("t6_rst_valid", 32'(valid3), 32'd0);
        check("t6_rst_busy", 32'(busy3), 32'd0);
        check("t6_rst_done", 32'(done3), 32'd0);
        check("t6_rst_stall", 32'(stall3), 32'd0);
        check("t6_rst_addr_dut1", 32'(addr), 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        check("t6_idle_after_rst", 32'(busy3), 32'd0);
        check("t6_no_done_on_rst", 32'(done3_cnt), 32'd0);
        check("t6_reads_before_rst", 32'(rd3_cnt), 32'd1);
        base3 = 16'h0040;
        num3 = 16'd1;
        start3 = 1'b1;
        kc = cyc;
        step();
        start3 = 1'b0;
        check("t6_restart_rd_en", 32'(rd_en3), 32'd1);
        check("t6_restart_addr", 32'(addr3), 32'h0040);
        wait_sig(2, 12, "t6_valid_timeout");
        check("t6_valid_cycle", 32'(cyc - kc), 32'd5);
        check("t6_lanes", {q4, q3, q2, q1}, mem_word(16'h0040));
        wait_sig(3, 10, "t6_done_timeout");
        step();
        check("t6_done_pulses", 32'(done3_cnt), 32'd1);
        check("t6_reads_total", 32'(rd3_cnt), 32'd2);
        check("t6_busy_end", 32'(busy3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
